// File: rtl/qupls_decode_fu_split.sv
// Decode-group FU classifier and issue-port splitter for the Qupls front end.
// Optional per-class issue statistics: define QUPLS_FU_SPLIT_STATS_EN.
package qupls_decode_fu_split_pkg;

  typedef struct packed {
    logic [6:0]  func;
    logic [17:0] fields;
    logic [6:0]  opcode;
  } instruction_t;

  typedef enum logic [1:0] {
    FC_OTHER = 2'b00,
    FC_ALU   = 2'b01,
    FC_MUL   = 2'b10
  } fu_class_t;

  localparam logic [6:0]
    OP_SYS    = 7'd0,  OP_R2     = 7'd2,  OP_CSR    = 7'd3,  OP_ADDI   = 7'd4,
    OP_SUBFI  = 7'd5,  OP_CMPI   = 7'd6,  OP_MULI   = 7'd7,  OP_ANDI   = 7'd8,
    OP_ORI    = 7'd9,  OP_EORI   = 7'd10, OP_SLTI   = 7'd11, OP_DIVI   = 7'd12,
    OP_ADDSI  = 7'd13, OP_ANDSI  = 7'd14, OP_ORSI   = 7'd15, OP_EORSI  = 7'd16,
    OP_SHIFT  = 7'd17, OP_MOV    = 7'd18, OP_LDAX   = 7'd19, OP_AIPSI  = 7'd20,
    OP_PFXA32 = 7'd21, OP_PFXB32 = 7'd22, OP_PFXC32 = 7'd23, OP_QFEXT  = 7'd24,
    OP_REGC   = 7'd25, OP_VEC    = 7'd26, OP_VECZ   = 7'd27, OP_NOP    = 7'd28,
    OP_PUSH   = 7'd29, OP_POP    = 7'd30, OP_ENTER  = 7'd31, OP_LEAVE  = 7'd32,
    OP_ATOM   = 7'd33, OP_FENCE  = 7'd34, OP_BSR    = 7'd35, OP_JSR    = 7'd36,
    OP_VADDI  = 7'd37, OP_VCMPI  = 7'd38, OP_VMULI  = 7'd39, OP_VDIVI  = 7'd40,
    OP_VANDI  = 7'd41, OP_VORI   = 7'd42, OP_VEORI  = 7'd43, OP_BCC    = 7'd48,
    OP_LDB    = 7'd56, OP_STB    = 7'd60;

  localparam logic [6:0]
    FN_ADD   = 7'd0,  FN_SUB   = 7'd1,  FN_CMP   = 7'd2,  FN_AND   = 7'd4,
    FN_OR    = 7'd5,  FN_EOR   = 7'd6,  FN_NAND  = 7'd8,  FN_NOR   = 7'd9,
    FN_ENOR  = 7'd10, FN_MUL   = 7'd16, FN_MULW  = 7'd17, FN_MULU  = 7'd18,
    FN_MULUW = 7'd19, FN_DIV   = 7'd20, FN_DIVU  = 7'd21, FN_MOD   = 7'd22,
    FN_SEQ   = 7'd32, FN_SNE   = 7'd33, FN_SLT   = 7'd34, FN_SLE   = 7'd35,
    FN_SLTU  = 7'd36, FN_SLEU  = 7'd37, FN_ZSEQ  = 7'd40, FN_ZSNE  = 7'd41,
    FN_ZSLT  = 7'd42, FN_ZSLE  = 7'd43, FN_ZSLTU = 7'd44, FN_ZSLEU = 7'd45;

  function automatic fu_class_t classify(input instruction_t ins, input logic split);
    fu_class_t md;
    md = split ? FC_MUL : FC_ALU;
    classify = FC_OTHER;
    case (ins.opcode)
      OP_R2:
        case (ins.func) inside
          FN_ADD, FN_SUB, FN_CMP, FN_AND, FN_OR, FN_EOR, FN_NAND, FN_NOR, FN_ENOR,
          [FN_SEQ:FN_SLEU], [FN_ZSEQ:FN_ZSLEU]:
            classify = FC_ALU;
          FN_MUL, FN_MULW, FN_MULU, FN_MULUW, FN_DIV, FN_DIVU:
            classify = md;
          default:
            classify = FC_OTHER;
        endcase
      OP_MULI, OP_VMULI, OP_DIVI, OP_VDIVI:
        classify = md;
      OP_ADDI, OP_VADDI, OP_SUBFI, OP_CMPI, OP_VCMPI, OP_ANDI, OP_ORI, OP_EORI,
      OP_VANDI, OP_VORI, OP_VEORI, OP_SLTI, OP_AIPSI, OP_ADDSI, OP_ANDSI, OP_ORSI,
      OP_EORSI, OP_SHIFT, OP_CSR, OP_MOV, OP_LDAX, OP_PFXA32, OP_PFXB32, OP_PFXC32,
      OP_QFEXT, OP_REGC, OP_VEC, OP_VECZ, OP_NOP, OP_PUSH, OP_POP, OP_ENTER,
      OP_LEAVE, OP_ATOM, OP_FENCE, OP_BSR, OP_JSR:
        classify = FC_ALU;
      default:
        classify = FC_OTHER;
    endcase
  endfunction

endpackage

module qupls_decode_fu_split
  import qupls_decode_fu_split_pkg::*;
#(
  parameter int unsigned LANES        = 4,
  parameter int unsigned ALU_PORTS    = 2,
  parameter int unsigned MUL_PORTS    = 1,
  parameter int unsigned SPLIT_MULDIV = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES-1:0]            in_lane_v,
  input  instruction_t [LANES-1:0]    in_instr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output instruction_t [LANES-1:0]    out_instr,
  output logic [LANES-1:0]            out_mask,
  output logic [LANES-1:0][1:0]       out_class,
  output logic                        out_last,
  input  logic                        stat_clr
`ifdef QUPLS_FU_SPLIT_STATS_EN
  ,
  output logic [31:0]                 stat_alu,
  output logic [31:0]                 stat_mul,
  output logic [31:0]                 stat_oth,
  output logic [31:0]                 stat_split
`endif
);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t                     state;
  logic [LANES-1:0]           pend;
  logic [LANES-1:0]           pend_nxt;
  logic [LANES-1:0]           mask;
  logic                       first;
  instruction_t [LANES-1:0]   instr_q;
  logic [LANES-1:0][1:0]      cls_q;
  fu_class_t                  lane_cls [LANES];
  logic                       load;
  logic                       take;

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_cls[i] = classify(in_instr[i], SPLIT_MULDIV != 0);
    end
  end

  // Greedy program-order walk: once a lane busts its class budget, every younger lane waits.
  always_comb begin
    int unsigned alu_n;
    int unsigned mul_n;
    logic        stop;
    alu_n = 0;
    mul_n = 0;
    stop  = 1'b0;
    mask  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (pend[i] && !stop) begin
        if (cls_q[i] == FC_ALU) begin
          if (alu_n >= ALU_PORTS) stop = 1'b1;
          else alu_n = alu_n + 1;
        end else if (cls_q[i] == FC_MUL) begin
          if (mul_n >= MUL_PORTS) stop = 1'b1;
          else mul_n = mul_n + 1;
        end
        if (!stop) mask[i] = 1'b1;
      end
    end
  end

  assign out_valid = (state == HOLD);
  assign out_mask  = mask;
  assign out_last  = out_valid && (mask == pend);
  assign in_ready  = !out_valid || (out_ready && out_last);
  assign out_instr = instr_q;
  assign out_class = cls_q;
  assign take      = out_valid && out_ready;
  assign load      = in_valid && in_ready;

  always_comb begin
    pend_nxt = pend;
    if (load) pend_nxt = in_lane_v;
    else if (take) pend_nxt = pend & ~mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      pend    <= '0;
      first   <= 1'b0;
      instr_q <= '0;
      cls_q   <= '0;
    end else begin
      pend  <= pend_nxt;
      state <= (|pend_nxt) ? HOLD : EMPTY;
      if (load) begin
        instr_q <= in_instr;
        first   <= 1'b1;
        for (int unsigned i = 0; i < LANES; i++) begin
          cls_q[i] <= lane_cls[i];
        end
      end else if (take) begin
        first <= 1'b0;
      end
    end
  end

`ifdef QUPLS_FU_SPLIT_STATS_EN
  logic [31:0] n_alu;
  logic [31:0] n_mul;
  logic [31:0] n_oth;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    sat_add = s[32] ? '1 : s[31:0];
  endfunction

  always_comb begin
    n_alu = '0;
    n_mul = '0;
    n_oth = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        if (cls_q[i] == FC_ALU) n_alu = n_alu + 32'd1;
        else if (cls_q[i] == FC_MUL) n_mul = n_mul + 32'd1;
        else n_oth = n_oth + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_alu   <= '0;
      stat_mul   <= '0;
      stat_oth   <= '0;
      stat_split <= '0;
    end else if (take) begin
      stat_alu <= sat_add(stat_alu, n_alu);
      stat_mul <= sat_add(stat_mul, n_mul);
      stat_oth <= sat_add(stat_oth, n_oth);
      if (first && !out_last) stat_split <= sat_add(stat_split, 32'd1);
    end
  end
`else
  logic stat_clr_unused;
  assign stat_clr_unused = stat_clr;
`endif

endmodule

// File: tb/tb_qupls_decode_fu_split.sv
// Bench for qupls_decode_fu_split: directed vector table, hand sequences and a
// randomized run against a lookup-table/scoreboard model, for both SPLIT_MULDIV settings.
module tb_qupls_decode_fu_split;
  import qupls_decode_fu_split_pkg::*;

  localparam int A_PORTS = 2;
  localparam int M_PORTS = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_s      [2];
  logic                  in_valid_s [2];
  logic                  in_ready_s [2];
  logic                  out_valid_s[2];
  logic                  out_ready_s[2];
  logic                  out_last_s [2];
  logic                  stat_clr_s [2];
  logic [3:0]            lane_v_s   [2];
  logic [3:0]            mask_s     [2];
  instruction_t [3:0]    instr_s    [2];
  instruction_t [3:0]    oinstr_s   [2];
  logic [3:0][1:0]       cls_s      [2];
`ifdef QUPLS_FU_SPLIT_STATS_EN
  logic [31:0]           st_alu[2], st_mul[2], st_oth[2], st_split[2];
`endif

  qupls_decode_fu_split #(.LANES(4), .ALU_PORTS(A_PORTS), .MUL_PORTS(M_PORTS), .SPLIT_MULDIV(1)) u_split (
    .clk(clk), .rst(rst_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .in_lane_v(lane_v_s[0]), .in_instr(instr_s[0]), .out_valid(out_valid_s[0]),
    .out_ready(out_ready_s[0]), .out_instr(oinstr_s[0]), .out_mask(mask_s[0]),
    .out_class(cls_s[0]), .out_last(out_last_s[0]), .stat_clr(stat_clr_s[0])
`ifdef QUPLS_FU_SPLIT_STATS_EN
    , .stat_alu(st_alu[0]), .stat_mul(st_mul[0]), .stat_oth(st_oth[0]), .stat_split(st_split[0])
`endif
  );

  qupls_decode_fu_split #(.LANES(4), .ALU_PORTS(A_PORTS), .MUL_PORTS(M_PORTS), .SPLIT_MULDIV(0)) u_merge (
    .clk(clk), .rst(rst_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .in_lane_v(lane_v_s[1]), .in_instr(instr_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(out_ready_s[1]), .out_instr(oinstr_s[1]), .out_mask(mask_s[1]),
    .out_class(cls_s[1]), .out_last(out_last_s[1]), .stat_clr(stat_clr_s[1])
`ifdef QUPLS_FU_SPLIT_STATS_EN
    , .stat_alu(st_alu[1]), .stat_mul(st_mul[1]), .stat_oth(st_oth[1]), .stat_split(st_split[1])
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference classification tables: 0 other, 1 alu, 2 mul/div, 3 look up by func.
  logic [1:0] op_tab [128];
  logic [1:0] fn_tab [128];

  task automatic init_tables();
    logic [6:0] alu_ops[$];
    logic [6:0] md_ops[$];
    logic [6:0] alu_fns[$];
    logic [6:0] md_fns[$];
    alu_ops = '{OP_ADDI, OP_VADDI, OP_SUBFI, OP_CMPI, OP_VCMPI, OP_ANDI, OP_ORI, OP_EORI,
                OP_VANDI, OP_VORI, OP_VEORI, OP_SLTI, OP_AIPSI, OP_ADDSI, OP_ANDSI, OP_ORSI,
                OP_EORSI, OP_SHIFT, OP_CSR, OP_MOV, OP_LDAX, OP_PFXA32, OP_PFXB32, OP_PFXC32,
                OP_QFEXT, OP_REGC, OP_VEC, OP_VECZ, OP_NOP, OP_PUSH, OP_POP, OP_ENTER,
                OP_LEAVE, OP_ATOM, OP_FENCE, OP_BSR, OP_JSR};
    md_ops  = '{OP_MULI, OP_VMULI, OP_DIVI, OP_VDIVI};
    alu_fns = '{FN_ADD, FN_SUB, FN_CMP, FN_AND, FN_OR, FN_EOR, FN_NAND, FN_NOR, FN_ENOR};
    md_fns  = '{FN_MUL, FN_MULW, FN_MULU, FN_MULUW, FN_DIV, FN_DIVU};
    for (int i = 0; i < 128; i++) begin
      op_tab[i] = 2'd0;
      fn_tab[i] = 2'd0;
    end
    foreach (alu_ops[i]) op_tab[alu_ops[i]] = 2'd1;
    foreach (md_ops[i])  op_tab[md_ops[i]]  = 2'd2;
    op_tab[OP_R2] = 2'd3;
    foreach (alu_fns[i]) fn_tab[alu_fns[i]] = 2'd1;
    foreach (md_fns[i])  fn_tab[md_fns[i]]  = 2'd2;
    for (int f = FN_SEQ; f <= FN_SLEU; f++)   fn_tab[f] = 2'd1;
    for (int f = FN_ZSEQ; f <= FN_ZSLEU; f++) fn_tab[f] = 2'd1;
  endtask

  function automatic logic [1:0] mclass(input instruction_t ins, input bit split);
    logic [1:0] k;
    k = op_tab[ins.opcode];
    if (k == 2'd3) k = fn_tab[ins.func];
    if (k == 2'd2 && !split) k = 2'd1;
    return k;
  endfunction

  typedef struct packed {
    logic [3:0]         mask;
    logic               last;
    logic [3:0][1:0]    cls;
    instruction_t [3:0] instr;
  } slice_t;

  slice_t sbq[$];

  // Cut the valid lanes into consecutive runs that each respect the port budgets.
  function automatic void push_group(input instruction_t [3:0] ins, input logic [3:0] lv, input bit split);
    logic [3:0][1:0] c;
    logic [3:0]      cur;
    int              na, nm;
    slice_t          s;
    for (int i = 0; i < 4; i++) c[i] = mclass(ins[i], split);
    cur = '0; na = 0; nm = 0;
    for (int i = 0; i < 4; i++) begin
      if (lv[i]) begin
        if ((c[i] == 2'd1 && na == A_PORTS) || (c[i] == 2'd2 && nm == M_PORTS)) begin
          s = '{mask: cur, last: 1'b0, cls: c, instr: ins};
          sbq.push_back(s);
          cur = '0; na = 0; nm = 0;
        end
        cur[i] = 1'b1;
        if (c[i] == 2'd1) na++;
        if (c[i] == 2'd2) nm++;
      end
    end
    if (cur != 0) begin
      s = '{mask: cur, last: 1'b1, cls: c, instr: ins};
      sbq.push_back(s);
    end
  endfunction

  function automatic instruction_t mk(input logic [6:0] op, input logic [6:0] fn);
    instruction_t r;
    r.opcode = op;
    r.func   = fn;
    r.fields = 18'h2a5c3;
    return r;
  endfunction

  function automatic instruction_t [3:0] grp(input instruction_t i0, i1, i2, i3);
    instruction_t [3:0] r;
    r[0] = i0; r[1] = i1; r[2] = i2; r[3] = i3;
    return r;
  endfunction

  function automatic logic [3:0][1:0] cl4(input logic [1:0] c0, c1, c2, c3);
    logic [3:0][1:0] r;
    r[0] = c0; r[1] = c1; r[2] = c2; r[3] = c3;
    return r;
  endfunction

  task automatic do_reset(input int d);
    rst_s[d] = 1'b1; in_valid_s[d] = 1'b0; out_ready_s[d] = 1'b0; stat_clr_s[d] = 1'b0;
    lane_v_s[d] = '0; instr_s[d] = '0;
    @(posedge clk); #1;
    rst_s[d] = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid_s[d], 1'b0);
    check("rst_in_ready", in_ready_s[d], 1'b1);
    check("rst_out_mask", mask_s[d], 4'b0);
    check("rst_out_last", out_last_s[d], 1'b0);
    check("rst_out_class", cls_s[d], 8'b0);
    check("rst_out_instr", oinstr_s[d], 128'b0);
`ifdef QUPLS_FU_SPLIT_STATS_EN
    check("rst_stats", {st_alu[d], st_mul[d], st_oth[d], st_split[d]}, 128'b0);
`endif
  endtask

  typedef struct {
    int                 d;
    logic [3:0]         lane_v;
    instruction_t [3:0] ins;
    logic [3:0][1:0]    cls;
    int                 nsl;
    logic [3:0]         m0;
    logic [3:0]         m1;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    logic [3:0] em;
    do_reset(v.d);
    in_valid_s[v.d] = 1'b1; lane_v_s[v.d] = v.lane_v; instr_s[v.d] = v.ins; out_ready_s[v.d] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[v.d] = 1'b0;
    for (int k = 0; k < v.nsl; k++) begin
      em = (k == 0) ? v.m0 : v.m1;
      @(negedge clk);
      check("vec_valid", out_valid_s[v.d], 1'b1);
      check("vec_mask", mask_s[v.d], em);
      check("vec_last", out_last_s[v.d], k == v.nsl - 1);
      check("vec_in_ready", in_ready_s[v.d], k == v.nsl - 1);
      check("vec_class", cls_s[v.d], v.cls);
      check("vec_instr", oinstr_s[v.d], v.ins);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("vec_done_valid", out_valid_s[v.d], 1'b0);
    check("vec_done_in_ready", in_ready_s[v.d], 1'b1);
  endtask

  function automatic instruction_t rnd_instr();
    logic [6:0] op;
    op = ($urandom_range(0, 9) < 4) ? OP_R2 : 7'($urandom_range(0, 63));
    return mk(op, 7'($urandom_range(0, 50)));
  endfunction

  task automatic run_random(input int d, input int ncyc);
    bit     split;
    bit     exp_ir;
    slice_t s;
    split = (d == 0);
    sbq.delete();
    do_reset(d);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      exp_ir = (sbq.size() == 0) || (out_ready_s[d] && sbq.size() == 1);
      check("rnd_out_valid", out_valid_s[d], sbq.size() != 0);
      check("rnd_in_ready", in_ready_s[d], exp_ir);
      if (sbq.size() != 0) begin
        s = sbq[0];
        check("rnd_mask", mask_s[d], s.mask);
        check("rnd_last", out_last_s[d], s.last);
        check("rnd_class", cls_s[d], s.cls);
        check("rnd_instr", oinstr_s[d], s.instr);
        if (out_ready_s[d]) void'(sbq.pop_front());
      end
      if (in_valid_s[d] && exp_ir) push_group(instr_s[d], lane_v_s[d], split);
      @(posedge clk); #1;
      in_valid_s[d]  = ($urandom_range(0, 2) != 0);
      lane_v_s[d]    = ($urandom_range(0, 9) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      out_ready_s[d] = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 4; i++) instr_s[d][i] = rnd_instr();
    end
    in_valid_s[d] = 1'b0;
  endtask

  initial begin
    instruction_t [3:0] nops, movs;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; in_valid_s[d] = 1'b0; out_ready_s[d] = 1'b0; stat_clr_s[d] = 1'b0;
      lane_v_s[d] = '0; instr_s[d] = '0;
    end
    init_tables();
    nops = grp(mk(OP_NOP, 0), mk(OP_NOP, 0), mk(OP_NOP, 0), mk(OP_NOP, 0));
    movs = grp(mk(OP_MOV, 3), mk(OP_MOV, 3), mk(OP_MOV, 3), mk(OP_MOV, 3));

    vecs[0] = '{0, 4'b1111, nops, cl4(2'b01, 2'b01, 2'b01, 2'b01), 2, 4'b0011, 4'b1100};
    vecs[1] = '{0, 4'b1111, grp(mk(OP_R2, FN_MUL), mk(OP_R2, FN_MULU), mk(OP_ADDI, 0), mk(OP_SYS, 0)),
                cl4(2'b10, 2'b10, 2'b01, 2'b00), 2, 4'b0001, 4'b1110};
    vecs[2] = '{1, 4'b1111, grp(mk(OP_R2, FN_MUL), mk(OP_R2, FN_MULU), mk(OP_ADDI, 0), mk(OP_SYS, 0)),
                cl4(2'b01, 2'b01, 2'b01, 2'b00), 2, 4'b0011, 4'b1100};
    vecs[3] = '{0, 4'b1010, movs, cl4(2'b01, 2'b01, 2'b01, 2'b01), 1, 4'b1010, 4'b0000};
    vecs[4] = '{0, 4'b0000, movs, cl4(2'b01, 2'b01, 2'b01, 2'b01), 0, 4'b0000, 4'b0000};
    vecs[5] = '{0, 4'b1111, grp(mk(OP_SYS, 0), mk(OP_LDB, 0), mk(OP_R2, FN_DIV), mk(OP_MULI, 0)),
                cl4(2'b00, 2'b00, 2'b10, 2'b10), 2, 4'b0111, 4'b1000};
    foreach (vecs[i]) run_vec(vecs[i]);

    // Stall mid-group, then present the next group during the final-slice accept.
    do_reset(0);
    in_valid_s[0] = 1'b1; lane_v_s[0] = 4'b1111; instr_s[0] = nops; out_ready_s[0] = 1'b0;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", out_valid_s[0], 1'b1);
      check("stall_mask", mask_s[0], 4'b0011);
      check("stall_instr", oinstr_s[0], nops);
      check("stall_in_ready", in_ready_s[0], 1'b0);
      @(posedge clk); #1;
    end
    out_ready_s[0] = 1'b1;
    @(negedge clk);
    check("resume_mask", mask_s[0], 4'b0011);
    @(posedge clk); #1;
    in_valid_s[0] = 1'b1; lane_v_s[0] = 4'b1111; instr_s[0] = movs;
    @(negedge clk);
    check("b2b_final_mask", mask_s[0], 4'b1100);
    check("b2b_final_last", out_last_s[0], 1'b1);
    check("b2b_in_ready", in_ready_s[0], 1'b1);
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    @(negedge clk);
    check("b2b_next_valid", out_valid_s[0], 1'b1);
    check("b2b_next_mask", mask_s[0], 4'b0011);
    check("b2b_next_instr", oinstr_s[0], movs);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_drain_mask", mask_s[0], 4'b1100);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_drain_done", out_valid_s[0], 1'b0);

    // Reset while lanes 2..3 are still pending.
    do_reset(0);
    in_valid_s[0] = 1'b1; lane_v_s[0] = 4'b1111; instr_s[0] = nops; out_ready_s[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    @(posedge clk); #1;
    out_ready_s[0] = 1'b0;
    @(negedge clk);
    check("pre_rst_mask", mask_s[0], 4'b1100);
    rst_s[0] = 1'b1;
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", out_valid_s[0], 1'b0);
    check("mid_rst_in_ready", in_ready_s[0], 1'b1);
    check("mid_rst_mask", mask_s[0], 4'b0);
`ifdef QUPLS_FU_SPLIT_STATS_EN
    check("mid_rst_stats", {st_alu[0], st_mul[0], st_oth[0], st_split[0]}, 128'b0);
    in_valid_s[0] = 1'b1; lane_v_s[0] = 4'b1111; instr_s[0] = nops; out_ready_s[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("stat_alu", st_alu[0], 32'd4);
    check("stat_split", st_split[0], 32'd1);
    check("stat_mul_oth", {st_mul[0], st_oth[0]}, 64'd0);
    stat_clr_s[0] = 1'b1;
    @(posedge clk); #1;
    stat_clr_s[0] = 1'b0;
    @(negedge clk);
    check("stat_clr", {st_alu[0], st_split[0]}, 64'd0);
`endif

    run_random(0, 2000);
    run_random(1, 2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qupls_decode_fu_split.md
Name: qupls_decode_fu_split

Overview:
- Multi-lane successor to the single-instruction ALU classifier.
- Takes a decode group of LANES instructions, classifies each lane as ALU, MUL or OTHER, and registers the group.
- Emits the group in program-order slices so that no slice exceeds the per-cycle ALU and multiply/divide issue-port budgets.
- Sits between the decode stage and rename/queue; valid/ready handshake on both sides.

Parameters:
- LANES, 4, instructions per decode group (1..8).
- ALU_PORTS, 2, maximum ALU-class lanes per output slice (>=1).
- MUL_PORTS, 1, maximum MUL-class lanes per output slice (>=1).
- SPLIT_MULDIV, 1: 1 = multiply/divide ops form class MUL; 0 = they are class ALU.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input group valid.
- in_ready  out  1  block can accept a group this cycle.
- in_lane_v  in  LANES  per-lane valid.
- in_instr  in  LANES x $bits(instruction_t)  instructions, lane 0 oldest.
- out_valid  out  1  slice valid.
- out_ready  in  1  consumer accepts slice.
- out_instr  out  LANES x $bits(instruction_t)  held group.
- out_mask  out  LANES  lanes issued in this slice.
- out_class  out  LANES x 2  per-lane class: 00 OTHER, 01 ALU, 10 MUL.
- out_last  out  1  slice is final slice of group.
- stat_clr  in  1  clear statistics (used only with the optional feature).

Behaviour:
- Classification is combinational per lane, registered at group load.
- ALU class: OP_R2 with FN_ADD, FN_SUB, FN_CMP, FN_AND, FN_OR, FN_EOR, FN_NAND, FN_NOR, FN_ENOR, FN_SEQ..FN_SLEU, FN_ZSEQ..FN_ZSLEU.
- Also ALU class: OP_ADDI/VADDI, OP_SUBFI, OP_CMPI/VCMPI, OP_ANDI/ORI/EORI and their vector forms, OP_SLTI, OP_AIPSI, all *SI forms, OP_SHIFT, OP_CSR, OP_MOV, OP_LDAX, OP_PFXA32/B32/C32, OP_QFEXT, OP_REGC, OP_VEC/VECZ, OP_NOP, OP_PUSH/POP/ENTER/LEAVE/ATOM, OP_FENCE, OP_BSR/JSR.
- MUL class: OP_R2 FN_MUL/MULW/MULU/MULUW/DIV/DIVU, OP_MULI/VMULI, OP_DIVI/VDIVI; these are ALU class when SPLIT_MULDIV=0.
- OTHER class: everything else, including OP_SYS and unknown opcodes. OTHER lanes carry no budget.
- State: pend[LANES], the lanes not yet issued. States: EMPTY (pend==0) and HOLD (pend!=0).
- out_valid = HOLD.
- out_mask: walk pend from lane 0 upward, counting ALU and MUL lanes. Stop at the first lane whose class count would exceed its port budget. out_mask = pend lanes below the stop point.
- out_last = (out_mask == pend).
- On out_valid & out_ready: pend <= pend & ~out_mask.
- in_ready = EMPTY | (out_valid & out_ready & out_last); no bubble between groups.
- Load on in_valid & in_ready: latch in_instr, classes, pend <= in_lane_v. Latency is 1 cycle from acceptance to first slice.
- Group with in_lane_v == 0: consumed, state stays EMPTY, no output slice.
- Invalid lanes are never issued and never count against the budget.
- out_ready low: all outputs held stable.
- rst: pend <= 0, out_valid=0, out_mask=0, out_last=0, out_class=0, out_instr=0, in_ready=1 on the first post-reset cycle. Any in-flight group is discarded.
- Slice count per group is at most the number of budgeted lanes; the first lane of pend is always issued, which guarantees forward progress.

Optional Feature:
- Macro QUPLS_FU_SPLIT_STATS_EN.
- When defined, adds outputs stat_alu, stat_mul, stat_oth (each 32 bit, count of issued lanes per class) and stat_split (32 bit, count of groups needing more than one slice).
- Counters update on each accepted slice and saturate at all-ones.
- Counters clear on rst or stat_clr. stat_clr has priority over a same-cycle increment.
- When not defined: no counters are built and stat_clr is ignored.

Test Plan:
- Reset, LANES=4, ALU_PORTS=2. Load 4 valid OP_NOP, out_ready=1 -> cycle+1: mask 0011, last=0; cycle+2: mask 1100, last=1; in_ready=1 on cycle+2.
- Group {FN_MUL, FN_MULU, OP_ADDI, OP_SYS}, MUL_PORTS=1, SPLIT_MULDIV=1 -> class {10,10,01,00}; slice1 mask 0001, slice2 mask 1110.
- Same group with SPLIT_MULDIV=0, ALU_PORTS=2 -> class {01,01,01,00}; slices 0011 then 1100.
- in_lane_v=1010, four OP_MOV -> single slice, mask 1010, last=1.
- out_ready held low 3 cycles mid-group -> out_mask and out_instr stable, in_ready=0. Next group presented during the final-slice accept cycle -> loaded with no idle cycle.
- rst asserted while pend=1100 -> next cycle out_valid=0, in_ready=1. With QUPLS_FU_SPLIT_STATS_EN: stats zero; after the two-slice NOP group, stat_alu=4 and stat_split=1.
